ascii_dec_tx: RTL and testbench
===============================

// Module: ascii_dec_tx
// PURPOSE
//   Transmit side of the adder's ASCII byte bus. Takes one unsigned binary result word and
//   streams it as ASCII decimal digits ('0'..'9' = 8'h30..8'h39), most significant first,
//   on an 8-bit valid/ready byte bus, with leading zeros suppressed.
//   Sits between the adder datapath and the byte-bus consumer (bench monitor or UART framer).
// PARAMETERS
//   VAL_W  16  width of the binary input value
//   NDIG    5  BCD digit slots; must satisfy 10**NDIG > 2**VAL_W-1 (16 -> 5)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_value is valid
//   in_ready   out  1      block can accept a value
//   in_value   in   VAL_W  unsigned binary value to print
//   out_valid  out  1      out_data holds a digit
//   out_ready  in   1      consumer takes the digit this cycle
//   out_data   out  8      ASCII digit
//   out_last   out  1      high with the final digit of the number
//   busy       out  1      high in any state other than IDLE
// BEHAVIOUR
//   Reset (async assert, sync release): state IDLE; in_ready=1; out_valid=0; out_data=8'h00;
//     out_last=0; busy=0. Reset mid-conversion or mid-stream discards the number; no partial resume.
//   Handshakes: transfer on valid&ready at the rising edge. in_ready=1 only in IDLE.
//     While out_valid=1 and out_ready=0, out_data/out_last are held stable.
//     out_valid never drops without a transfer, except on reset.
//   FSM: IDLE -> CONV on input accept (edge T0); value latched into the shift register, BCD cleared.
//     CONV: shift-add-3 (double dabble), one input bit per cycle, exactly VAL_W cycles.
//       On the last CONV cycle the index of the highest non-zero digit is computed (0 if all zero).
//       The FSM then enters SEND with that index loaded.
//     SEND: out_valid=1; out_data = 8'h30 + bcd[idx]; out_last = (idx==0).
//       On transfer: if idx==0 -> IDLE, else idx-1.
//   Latency: first out_valid at T0+VAL_W cycles. Back-to-back digits, one per cycle if out_ready=1.
//     A new value is accepted at the earliest one cycle after the last-digit transfer.
//   Width rules: each BCD digit is 4 bits, NDIG*4 total. A digit >=5 gets +3 before each shift.
//     out_data upper nibble is always 4'h3.
//   Boundaries: value 0 -> single '0' with out_last=1. Value 2**VAL_W-1 (65535) -> all 5 digits.
//     in_valid during CONV/SEND is ignored (not accepted, no loss: in_ready=0).
//     out_ready held high before out_valid has no effect.
// STRUCTURE
//   Package ascii_bus_pkg: ASCII_ZERO=8'h30; state enum {IDLE, CONV, SEND}.
//     The same package serves the receive-side digit decoder.
//   Sub-module bin2bcd_seq: sequential double-dabble converter.
//     Ports: start, bin, done, bcd[NDIG*4]. Top level holds the FSM, leading-zero priority
//     encoder and output register.
// TESTING
//   1 Reset: hold rst_n=0, then release -> in_ready=1, out_valid=0, busy=0. Assert rst_n=0
//     mid-SEND -> out_valid falls immediately.
//   2 in_value=5, out_ready=1 -> one byte 8'h35 with out_last=1, first valid at T0+16, then IDLE.
//   3 in_value=124 -> bytes 8'h31, 8'h32, 8'h34 on consecutive cycles; out_last only on 8'h34.
//   4 in_value=0 -> single 8'h30, out_last=1. in_value=65535 -> 36,35,35,33,35 (hex).
//   5 in_value=1005 with out_ready toggling 1/0 randomly -> 31,30,30,35, each held stable while
//     stalled; interior zeros kept.
//   6 in_valid held high continuously with values 7 then 42 -> second value accepted only after
//     '7' (8'h37) transfers; stream is 37 | 34 32, with out_last on 37 and on 32.

Source files
------------

// File: rtl/ascii_bus_pkg.sv
// Shared definitions for the ASCII byte bus (transmit encoder and receive decoder).
package ascii_bus_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SEND = 2'd2
  } state_t;

  // Double-dabble correction applied to one BCD digit before it is shifted.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, done pulses once bcd is final.
module bin2bcd_seq
  import ascii_bus_pkg::*;
#(
  parameter int VAL_W = 16,
  parameter int NDIG  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [VAL_W-1:0]    bin,
  output logic                done,
  output logic [NDIG*4-1:0]   bcd
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0]  sr;
  logic [CNT_W-1:0]  cnt;
  logic              run;
  logic [NDIG*4-1:0] bcd_q;
  logic [NDIG*4-1:0] bcd_adj;

  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    end
  end

  // The first shift is folded into the load (add-3 on an all-zero BCD is a no-op),
  // so the remaining VAL_W-1 shifts finish in time for done to land on the last CONV cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      done  <= 1'b0;
      bcd_q <= '0;
    end else if (start) begin
      bcd_q <= {{(NDIG*4-1){1'b0}}, bin[VAL_W-1]};
      sr    <= bin << 1;
      cnt   <= CNT_W'(1);
      run   <= 1'b1;
      done  <= 1'b0;
    end else if (run) begin
      bcd_q <= {bcd_adj[NDIG*4-2:0], sr[VAL_W-1]};
      sr    <= sr << 1;
      cnt   <= cnt + 1'b1;
      if (cnt == CNT_W'(VAL_W - 1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/ascii_dec_tx.sv
// Streams an unsigned binary value as ASCII decimal digits, MSD first, leading zeros suppressed.
module ascii_dec_tx
  import ascii_bus_pkg::*;
#(
  parameter int VAL_W = 16,
  parameter int NDIG  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  lead_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic [3:0]        sel_digit;
  logic [NDIG*4-1:0] bcd;
  logic              conv_done;
  logic              start;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == SEND);
  assign start     = in_valid & in_ready;

  bin2bcd_seq #(
    .VAL_W (VAL_W),
    .NDIG  (NDIG)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (in_value),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Highest non-zero digit wins; all-zero leaves index 0 so a lone '0' is sent.
  always_comb begin
    lead_idx = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] != 4'd0) lead_idx = IDX_W'(i);
    end
  end

  assign sel_idx = (state == CONV) ? lead_idx : idx - 1'b1;

  always_comb begin
    sel_digit = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (IDX_W'(i) == sel_idx) sel_digit = bcd[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      out_data <= 8'h00;
      out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= CONV;
        end
        CONV: begin
          if (conv_done) begin
            state    <= SEND;
            idx      <= lead_idx;
            out_data <= ASCII_ZERO + {4'h0, sel_digit};
            out_last <= (lead_idx == '0);
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx == '0) begin
              state    <= IDLE;
              out_last <= 1'b0;
            end else begin
              idx      <= idx - 1'b1;
              out_data <= ASCII_ZERO + {4'h0, sel_digit};
              out_last <= (idx == IDX_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_dec_tx.sv
// Directed bench for ascii_dec_tx: digit streams, latency, stalls, reset and input blocking.
module tb_ascii_dec_tx;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_data[$];
  logic       rx_last[$];
  int         rx_cyc[$];

  ascii_dec_tx #(
    .VAL_W (16),
    .NDIG  (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a value for one accept edge; optionally leave in_valid high with a follow-up value.
  task automatic offer(input logic [15:0] v, input bit keep, input logic [15:0] nxt);
    @(negedge clk);
    in_valid = 1'b1;
    in_value = v;
    @(posedge clk);
    #1;
    if (keep) in_value = nxt;
    else in_valid = 1'b0;
  endtask

  // Edges from the accept edge until out_valid is seen, bounded.
  task automatic latency(input string tag, input int exp);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 100);
    check(tag, n, exp);
  endtask

  task automatic capture(input int n, input bit stall);
    int  cyc = 0;
    bit  held = 0;
    logic [7:0] hd = '0;
    logic       hl = 1'b0;
    rx_data.delete();
    rx_last.delete();
    rx_cyc.delete();
    while (rx_data.size() < n && cyc < 300) begin
      @(negedge clk);
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hd);
        check("hold_last", out_last, hl);
      end
      if (out_valid && out_ready) begin
        rx_data.push_back(out_data);
        rx_last.push_back(out_last);
        rx_cyc.push_back(cyc);
        held = 0;
      end else if (out_valid) begin
        held = 1;
        hd   = out_data;
        hl   = out_last;
      end
      cyc++;
    end
    check("capture_count", rx_data.size(), n);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_stream(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                               input int n);
    logic [7:0] exp_b[5];
    exp_b = '{b0, b1, b2, b3, b4};
    for (int i = 0; i < n && i < rx_data.size(); i++) begin
      check({tag, "_data"}, rx_data[i], exp_b[i]);
      check({tag, "_last"}, rx_last[i], (i == n - 1) ? 1 : 0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_value  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // value 5: single digit, fixed latency, back to idle
    offer(16'd5, 0, 16'd0);
    check("conv_busy", busy, 1);
    check("conv_in_ready", in_ready, 0);
    latency("lat_5", 16);
    capture(1, 0);
    expect_stream("v5", 8'h35, 0, 0, 0, 0, 1);
    check("v5_idle_busy", busy, 0);
    check("v5_idle_ready", in_ready, 1);

    // value 124: three back-to-back digits
    offer(16'd124, 0, 16'd0);
    latency("lat_124", 16);
    capture(3, 0);
    expect_stream("v124", 8'h31, 8'h32, 8'h34, 0, 0, 3);
    check("v124_gap1", rx_cyc[1] - rx_cyc[0], 1);
    check("v124_gap2", rx_cyc[2] - rx_cyc[1], 1);

    // zero and full-scale boundaries
    offer(16'd0, 0, 16'd0);
    latency("lat_0", 16);
    capture(1, 0);
    expect_stream("v0", 8'h30, 0, 0, 0, 0, 1);
    offer(16'd65535, 0, 16'd0);
    latency("lat_max", 16);
    capture(5, 0);
    expect_stream("vmax", 8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 5);

    // 1005 with random back-pressure: interior zeros kept, held values stable
    offer(16'd1005, 0, 16'd0);
    latency("lat_1005", 16);
    capture(4, 1);
    expect_stream("v1005", 8'h31, 8'h30, 8'h30, 8'h35, 0, 4);

    // in_valid held high: 42 only accepted after '7' leaves
    offer(16'd7, 1, 16'd42);
    latency("lat_7", 16);
    capture(1, 0);
    expect_stream("v7", 8'h37, 0, 0, 0, 0, 1);
    check("v7_idle_ready", in_ready, 1);
    check("v7_idle_busy", busy, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("v42_accepted", busy, 1);
    latency("lat_42", 16);
    capture(2, 0);
    expect_stream("v42", 8'h34, 8'h32, 0, 0, 0, 2);

    // reset during SEND drops out_valid at once
    out_ready = 1'b0;
    offer(16'd65535, 0, 16'd0);
    latency("lat_rst", 16);
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_data", out_data, 8'h00);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("no_resume_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
